// File: rtl/dma_master_if.sv
// Bus bundle for dma_master: CPU-facing config port plus the sys_bus master1 beat port.
interface dma_master_if;
  logic        dma_we;
  logic [31:0] dma_adr;
  logic [31:0] dma_wdata;
  logic [31:0] dma_rdata;
  logic        mst_request;
  logic        mst_we;
  logic [31:0] mst_adr;
  logic [31:0] mst_wdata;
  logic [31:0] mst_rdata;
  logic        mst_grant;
  logic        int_sig_o;

  modport master (
    input  dma_we, dma_adr, dma_wdata, mst_rdata, mst_grant,
    output dma_rdata, mst_request, mst_we, mst_adr, mst_wdata, int_sig_o
  );

  modport slave (
    output dma_we, dma_adr, dma_wdata, mst_rdata, mst_grant,
    input  dma_rdata, mst_request, mst_we, mst_adr, mst_wdata, int_sig_o
  );
endinterface

// File: rtl/dma_master.sv
// Word-copy DMA engine acting as sys_bus master1, programmed through a slave register port.
// Optional fill mode (write SRC value repeatedly to DST) is enabled by defining DMA_FILL_EN.
module dma_master #(
  parameter int unsigned LEN_WIDTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  dma_master_if.master bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RD   = 2'd1;
  localparam logic [1:0] S_WR   = 2'd2;
  localparam logic [1:0] S_FIN  = 2'd3;

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic [29:0]          r_src;
  logic [29:0]          r_dst;
  logic [LEN_WIDTH-1:0] r_len;
  logic [31:0]          r_buf;
  logic                 r_ie;
  logic                 r_done;
  logic                 r_aborted;

  logic       w_busy;
  logic [2:0] w_sel;
  logic       w_ctrl_wr;
  logic       w_stat_wr;
  logic       w_start;
  logic       w_abort;
  logic       w_grant;
  logic       w_advance;
  logic       w_fill;
  logic       w_fill_start;
  logic       w_unused;

  assign w_busy    = (r_state != S_IDLE);
  assign w_sel     = bus.dma_adr[4:2];
  assign w_ctrl_wr = bus.dma_we && (w_sel == 3'd0);
  assign w_stat_wr = bus.dma_we && (w_sel == 3'd1);
  assign w_start   = w_ctrl_wr && bus.dma_wdata[0] && !w_busy;
  assign w_abort   = w_ctrl_wr && bus.dma_wdata[2] && ((r_state == S_RD) || (r_state == S_WR));
  assign w_grant   = bus.mst_request && bus.mst_grant;
  assign w_unused  = &{1'b0, bus.dma_adr[31:5], bus.dma_adr[1:0]};

`ifdef DMA_FILL_EN
  logic r_fill;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            r_fill <= 1'b0;
    else if (w_ctrl_wr) r_fill <= bus.dma_wdata[3];
  end

  assign w_fill       = r_fill;
  // A START written together with FILL must already take the fill path.
  assign w_fill_start = w_ctrl_wr ? bus.dma_wdata[3] : r_fill;
`else
  assign w_fill       = 1'b0;
  assign w_fill_start = 1'b0;
`endif

  // Next-state logic; abort beats a same-cycle grant and suppresses counter advance.
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    case (r_state)
      S_IDLE: if (w_start && (r_len != '0)) w_state_nxt = w_fill_start ? S_WR : S_RD;
      S_RD: begin
        if (w_abort)      w_state_nxt = S_IDLE;
        else if (w_grant) w_state_nxt = S_WR;
      end
      S_WR: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (w_grant) begin
          w_advance   = 1'b1;
          w_state_nxt = (r_len == LEN_WIDTH'(1)) ? S_FIN : (w_fill ? S_WR : S_RD);
        end
      end
      S_FIN:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Working registers, config writes and status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_src     <= '0;
      r_dst     <= '0;
      r_len     <= '0;
      r_buf     <= '0;
      r_ie      <= 1'b0;
      r_done    <= 1'b0;
      r_aborted <= 1'b0;
    end else begin
      if ((r_state == S_RD) && w_grant && !w_abort) r_buf <= bus.mst_rdata;

      if (w_advance) begin
        if (!w_fill) r_src <= r_src + 30'd1;
        r_dst <= r_dst + 30'd1;
        r_len <= r_len - LEN_WIDTH'(1);
      end else if (bus.dma_we && !w_busy) begin
        case (w_sel)
          3'd2:    r_src <= bus.dma_wdata[31:2];
          3'd3:    r_dst <= bus.dma_wdata[31:2];
          3'd4:    r_len <= bus.dma_wdata[LEN_WIDTH-1:0];
          default: ;
        endcase
      end

      if (w_ctrl_wr) r_ie <= bus.dma_wdata[1];

      // Set sources win over the CPU's W1C in the same cycle.
      if ((r_state == S_FIN) || (w_start && (r_len == '0))) r_done <= 1'b1;
      else if (w_start)                                     r_done <= 1'b0;
      else if (w_stat_wr && bus.dma_wdata[1])               r_done <= 1'b0;

      if (w_abort)                            r_aborted <= 1'b1;
      else if (w_start)                       r_aborted <= 1'b0;
      else if (w_stat_wr && bus.dma_wdata[2]) r_aborted <= 1'b0;
    end
  end

  always_comb begin
    bus.dma_rdata = '0;
    case (w_sel)
      3'd0:    bus.dma_rdata = {28'd0, w_fill, 1'b0, r_ie, 1'b0};
      3'd1:    bus.dma_rdata = {29'd0, r_aborted, r_done, w_busy};
      3'd2:    bus.dma_rdata = {r_src, 2'b00};
      3'd3:    bus.dma_rdata = {r_dst, 2'b00};
      3'd4:    bus.dma_rdata = 32'(r_len);
      default: bus.dma_rdata = '0;
    endcase
  end

  // Beat outputs decode straight from registered state, so reset drops them at once.
  assign bus.mst_request = (r_state == S_RD) || (r_state == S_WR);
  assign bus.mst_we      = (r_state == S_WR);
  assign bus.mst_adr     = (r_state == S_RD) ? {r_src, 2'b00} :
                           (r_state == S_WR) ? {r_dst, 2'b00} : 32'd0;
  assign bus.mst_wdata   = (r_state != S_WR) ? 32'd0 :
                           (w_fill ? {r_src, 2'b00} : r_buf);
  assign bus.int_sig_o   = r_done && r_ie;

endmodule
